core_run_ctrl: RTL and testbench
================================

Name: core_run_ctrl

Overview:
- Run sequencer for the single-cycle 9-bit core: owns the start/done handshake, the core reset, and the core clock-enable.
- Holds the core in reset while idle and applies a clean multi-cycle reset on every start.
- Enables execution, detects halt (PC == 8'hFF or HALT_ZEROS consecutive all-zero instructions), and enforces a cycle-budget timeout.
- Sits between the top-level bench pins (clk, reset, start, done) and the core's PC/register/memory enables.

Parameters:
- CLEAR_CYCLES, 2: number of cycles core_rst is held after a start edge (legal range 1..15).
- HALT_ZEROS, 2: number of consecutive mach_code == 9'b0 cycles in RUN that constitute a halt (legal range 1..7).
- HALT_PC, 8'hFF: PC value that forces a halt.
- CYC_W, 16: width of cycle_count.
- MAX_CYCLES, 1000: RUN-cycle budget before timeout; must be ≤ 2^CYC_W − 1.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  run request; a rising edge (sampled) launches a run.
- pc  in  8  current core PC.
- mach_code  in  9  current instruction from instruction memory.
- core_rst  out  1  active-high reset to PC, register file and LUT register.
- core_en  out  1  core advance enable; PC and all core writes are gated by it.
- busy  out  1  high in CLEAR, RUN and DRAIN.
- done  out  1  run finished; held until the next start edge.
- timeout  out  1  valid with done; 1 = budget exhausted, 0 = normal halt.
- cycle_count  out  CYC_W  number of RUN cycles in the current or last run.

Behaviour:
- Reset (reset == 0 at posedge):
  - Synchronous and takes priority over everything, including mid-run.
  - Next state IDLE; start_q = 0; counters = 0.
  - Outputs: core_rst = 1, core_en = 0, busy = 0, done = 0, timeout = 0, cycle_count = 0.
- Start detection:
  - start_q is start registered each cycle.
  - Start edge = start & ~start_q.
  - Edges are ignored in CLEAR, RUN and DRAIN.
- Outputs are Moore, decoded from the state register, plus the registered timeout and cycle_count. They change on the same edge as the state.
- IDLE:
  - core_rst = 1, core_en = 0, done = 0.
  - Start edge → CLEAR. Entering CLEAR clears cycle_count, zero_run and timeout.
- CLEAR:
  - core_rst = 1, core_en = 0, busy = 1.
  - clr_cnt counts up; after exactly CLEAR_CYCLES cycles in CLEAR → RUN.
- RUN:
  - core_rst = 0, core_en = 1, busy = 1.
  - cycle_count increments by 1 every RUN cycle.
  - zero_run becomes zero_run + 1 if mach_code == 0, otherwise 0.
  - Halt condition (evaluated on the current-cycle inputs): pc == HALT_PC, or (mach_code == 0 and zero_run == HALT_ZEROS − 1). Halt → DRAIN.
  - Otherwise, if pre-increment cycle_count == MAX_CYCLES − 1 → DONE with timeout = 1. In that case cycle_count reads MAX_CYCLES.
  - Halt and timeout in the same cycle: halt wins, timeout = 0.
- DRAIN:
  - core_en = 0, core_rst = 0, busy = 1.
  - Lasts one cycle so the last writeback settles, then → DONE.
- DONE:
  - done = 1, core_en = 0, core_rst = 0 (architectural state remains visible for dump), busy = 0.
  - cycle_count and timeout are held.
  - Start edge → CLEAR; done drops on that edge.
  - start held high from the previous run does not retrigger.
- Latency: start edge sampled at cycle t → core_rst high t+1 .. t+CLEAR_CYCLES → first RUN cycle at t+CLEAR_CYCLES+1.
- Halt latency: halt detected in RUN cycle h → DRAIN at h+1 → done = 1 from h+2.
- Width rules:
  - cycle_count is unsigned and never wraps, since MAX_CYCLES is within range.
  - zero_run is 3 bits and is compared only while in RUN.

Decomposition:
- Package core_ctrl_pkg holds:
  - typedef enum logic [2:0] run_state_t {IDLE, CLEAR, RUN, DRAIN, DONE};
  - localparams for the default HALT_PC and CLEAR_CYCLES.
- No sub-module. Edge detect, counters and FSM all live in core_run_ctrl (about 150–200 lines).

Test Plan:
- Reset released, start held 0 for 10 cycles → core_rst = 1, core_en = 0, done = 0, busy = 0 throughout.
- Start edge at cycle t, mach_code = 9'h0A3 constant, pc = t-relative count → core_rst high at t+1 and t+2; core_en high from t+3.
- Drive pc = 8'h05 then pc = 8'hFF on the 12th RUN cycle → DRAIN next cycle; done = 1 one cycle later; timeout = 0; cycle_count = 12.
- mach_code pattern nonzero, 0, nonzero, 0, 0 with HALT_ZEROS = 2 → halt detected on the second consecutive zero (5th RUN cycle); a single zero does not halt; cycle_count = 5.
- MAX_CYCLES = 20, never halt → done = 1, timeout = 1, cycle_count = 20. Repeat with pc = 8'hFF on RUN cycle 20 → timeout = 0.
- Mid-run and restart:
  - Mid-run reset at RUN cycle 7 → next cycle IDLE outputs, cycle_count = 0.
  - In DONE with start held high → no restart.
  - Drop start, then raise it → CLEAR; done = 0; cycle_count cleared.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared types and defaults for the core run sequencer.
// Also holds the state-to-output decode used by the controller.
package core_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} run_state_t;

    localparam logic [7:0] DEF_HALT_PC      = 8'hFF;
    localparam int         DEF_CLEAR_CYCLES = 2;

    typedef struct packed {
        logic core_rst;
        logic core_en;
        logic busy;
        logic done;
    } run_outs_t;

    // Moore decode; the controller registers the result next to the state.
    function automatic run_outs_t decode_outs(input run_state_t s);
        run_outs_t o;
        o = '0;
        case (s)
            IDLE:    o.core_rst = 1'b1;
            CLEAR:   begin o.core_rst = 1'b1; o.busy = 1'b1; end
            RUN:     begin o.core_en  = 1'b1; o.busy = 1'b1; end
            DRAIN:   o.busy = 1'b1;
            DONE:    o.done = 1'b1;
            default: o.core_rst = 1'b1;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/core_run_ctrl.sv
// Run sequencer for the 9-bit core: start/done handshake, core reset,
// core clock-enable, halt detection and cycle-budget timeout.
module core_run_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int         CLEAR_CYCLES = DEF_CLEAR_CYCLES,
    parameter int         HALT_ZEROS   = 2,
    parameter logic [7:0] HALT_PC      = DEF_HALT_PC,
    parameter int         CYC_W        = 16,
    parameter int         MAX_CYCLES   = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       pc,
    input  logic [8:0]       mach_code,
    output logic             core_rst,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CYC_W-1:0] cycle_count
);

    localparam logic [3:0]       CLR_LAST  = 4'(CLEAR_CYCLES - 1);
    localparam logic [2:0]       ZERO_LAST = 3'(HALT_ZEROS - 1);
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(MAX_CYCLES - 1);

    run_state_t state;
    run_outs_t  outs;
    logic       start_q;
    logic [3:0] clr_cnt;
    logic [2:0] zero_run;

    logic start_edge;
    logic code_zero;
    logic halt;

    assign start_edge = start & ~start_q;
    assign code_zero  = (mach_code == 9'd0);
    assign halt       = (pc == HALT_PC) || (code_zero && (zero_run == ZERO_LAST));

    assign core_rst = outs.core_rst;
    assign core_en  = outs.core_en;
    assign busy     = outs.busy;
    assign done     = outs.done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            outs        <= decode_outs(IDLE);
            start_q     <= 1'b0;
            clr_cnt     <= '0;
            zero_run    <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                IDLE, DONE: begin
                    // A start held high across a run never looks like an edge.
                    if (start_edge) begin
                        state       <= CLEAR;
                        outs        <= decode_outs(CLEAR);
                        clr_cnt     <= '0;
                        zero_run    <= '0;
                        cycle_count <= '0;
                        timeout     <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state <= RUN;
                        outs  <= decode_outs(RUN);
                    end else begin
                        clr_cnt <= clr_cnt + 4'd1;
                    end
                end
                RUN: begin
                    cycle_count <= cycle_count + 1'b1;
                    zero_run    <= code_zero ? zero_run + 3'd1 : 3'd0;
                    // Halt outranks an exhausted budget in the same cycle.
                    if (halt) begin
                        state <= DRAIN;
                        outs  <= decode_outs(DRAIN);
                    end else if (cycle_count == CYC_LAST) begin
                        state   <= DONE;
                        outs    <= decode_outs(DONE);
                        timeout <= 1'b1;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    outs  <= decode_outs(DONE);
                end
                default: begin
                    state <= IDLE;
                    outs  <= decode_outs(IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: timeline model checked every cycle,
// plus literal expectations at the key points of each run.
module tb_core_run_ctrl;

    localparam int CLR  = 2;
    localparam int HZ   = 2;
    localparam int MAXC = 20;
    localparam int CW   = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic [7:0]    pc;
    logic [8:0]    mach_code;
    logic          core_rst;
    logic          core_en;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycle_count;

    int n_chk  = 0;
    int n_fail = 0;

    core_run_ctrl #(
        .CLEAR_CYCLES(CLR),
        .HALT_ZEROS  (HZ),
        .HALT_PC     (8'hFF),
        .CYC_W       (CW),
        .MAX_CYCLES  (MAXC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pc         (pc),
        .mach_code  (mach_code),
        .core_rst   (core_rst),
        .core_en    (core_en),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timeline model: a run is described by the posedge that accepted its
    // start, how many run cycles have elapsed, and how/when it ended.
    int m_q = 0, m_pedge = 0, m_runlen = 0, m_zeros = 0, m_endq = 0;
    bit m_valid = 0, m_active = 0, m_ended = 0, m_halted = 0, m_to = 0, m_prev = 0;

    initial begin : model_and_compare
        bit edge_seen, accept;
        logic [CW+4:0] exp_v, got_v;
        forever begin
            @(posedge clk);
            m_q++;
            if (!reset) begin
                m_valid = 1; m_active = 0; m_ended = 0; m_halted = 0;
                m_to = 0; m_runlen = 0; m_prev = 0;
            end else begin
                edge_seen = start && !m_prev;
                m_prev    = start;
                accept = edge_seen && (!m_active ||
                         (m_ended && (m_to ? (m_q >= m_endq + 1) : (m_q >= m_endq + 2))));
                if (accept) begin
                    m_active = 1; m_pedge = m_q; m_runlen = 0; m_zeros = 0;
                    m_ended = 0; m_halted = 0; m_to = 0;
                end else if (m_active && !m_ended && (m_q - m_pedge >= CLR + 1)) begin
                    m_runlen++;
                    m_zeros = (mach_code == 9'd0) ? m_zeros + 1 : 0;
                    if (pc == 8'hFF || m_zeros >= HZ) begin
                        m_ended = 1; m_halted = 1; m_endq = m_q;
                    end else if (m_runlen == MAXC) begin
                        m_ended = 1; m_to = 1; m_endq = m_q;
                    end
                end
            end
            #1;
            if (m_valid) begin
                // {core_rst, core_en, busy, done, timeout, cycle_count}
                if (!m_active)
                    exp_v = {5'b10000, CW'(0)};
                else if (!m_ended)
                    exp_v = (m_q - m_pedge < CLR) ? {5'b10100, CW'(m_runlen)}
                                                  : {5'b01100, CW'(m_runlen)};
                else if (m_halted && m_q == m_endq)
                    exp_v = {5'b00100, CW'(m_runlen)};
                else
                    exp_v = {4'b0001, m_to, CW'(m_runlen)};
                got_v = {core_rst, core_en, busy, done, timeout, cycle_count};
                n_chk++;
                if (got_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL model_cmp q=%0d rst/en/busy/done/to=%b cnt=%0d, expected %b cnt=%0d",
                             m_q, got_v[CW+4:CW], got_v[CW-1:0], exp_v[CW+4:CW], exp_v[CW-1:0]);
                end
            end
        end
    end

    task automatic step(input logic s, input logic [7:0] p, input logic [8:0] m);
        @(negedge clk);
        start = s; pc = p; mach_code = m;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    logic [8:0] zpat [5];

    initial begin
        reset = 1'b0; start = 1'b0; pc = 8'd0; mach_code = 9'h0A3;
        zpat[0] = 9'h001; zpat[1] = 9'h000; zpat[2] = 9'h002;
        zpat[3] = 9'h000; zpat[4] = 9'h000;
        repeat (3) step(0, 8'd0, 9'h0A3);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) step(0, 8'd0, 9'h0A3);
        chk("idle_rst", core_rst, 1);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);

        // Run A: pc halt on the 12th run cycle
        step(1, 8'd0, 9'h0A3);
        step(1, 8'd1, 9'h0A3); chk("a_clr1_rst", core_rst, 1);
        step(1, 8'd2, 9'h0A3); chk("a_clr2_rst", core_rst, 1);
        for (int j = 1; j <= 12; j++) begin
            step(1, (j == 12) ? 8'hFF : 8'h05, 9'h0A3);
            if (j == 1) chk("a_first_run_en", core_en, 1);
        end
        step(1, 8'd0, 9'h0A3); chk("a_drain_en", core_en, 0);
        step(1, 8'd0, 9'h0A3); chk("a_done", done, 1);
        chk("a_timeout", timeout, 0);
        chk("a_count", cycle_count, 12);
        repeat (4) step(1, 8'd0, 9'h0A3);
        chk("a_held_start_no_restart", done, 1);

        // Run B: two consecutive zero instructions halt, a lone zero does not
        step(0, 8'd0, 9'h0A3);
        step(1, 8'd0, 9'h0A3);
        step(1, 8'd0, 9'h0A3); chk("b_restart_done", done, 0);
        chk("b_restart_cnt", cycle_count, 0);
        step(1, 8'd0, 9'h0A3);
        for (int j = 0; j < 5; j++) step(1, 8'h10, zpat[j]);
        step(0, 8'd0, 9'h0A3); chk("b_drain_busy", busy, 1);
        step(0, 8'd0, 9'h0A3); chk("b_done", done, 1);
        chk("b_count", cycle_count, 5);
        chk("b_timeout", timeout, 0);

        // Run C: budget exhausted
        step(1, 8'd0, 9'h0A3);
        step(1, 8'd0, 9'h0A3);
        step(1, 8'd0, 9'h0A3);
        for (int j = 1; j <= 20; j++) step(1, 8'(j), 9'h0A3);
        step(1, 8'd0, 9'h0A3); chk("c_done", done, 1);
        chk("c_timeout", timeout, 1);
        chk("c_count", cycle_count, 20);

        // Run D: halt on the last budget cycle wins over timeout
        step(0, 8'd0, 9'h0A3);
        step(1, 8'd0, 9'h0A3);
        step(1, 8'd0, 9'h0A3);
        step(1, 8'd0, 9'h0A3);
        for (int j = 1; j <= 20; j++) step(1, (j == 20) ? 8'hFF : 8'(j), 9'h0A3);
        step(1, 8'd0, 9'h0A3); chk("d_drain_done", done, 0);
        step(1, 8'd0, 9'h0A3); chk("d_done", done, 1);
        chk("d_timeout", timeout, 0);
        chk("d_count", cycle_count, 20);

        // Run E: reset in the middle of run cycle 7
        step(0, 8'd0, 9'h0A3);
        step(1, 8'd0, 9'h0A3);
        step(1, 8'd0, 9'h0A3);
        step(1, 8'd0, 9'h0A3);
        for (int j = 1; j <= 6; j++) step(1, 8'h20, 9'h0A3);
        step(0, 8'h20, 9'h0A3); reset = 1'b0;
        step(0, 8'd0, 9'h0A3); chk("e_rst_count", cycle_count, 0);
        chk("e_rst_core_rst", core_rst, 1);
        chk("e_rst_busy", busy, 0);
        chk("e_rst_en", core_en, 0);
        reset = 1'b1;
        repeat (3) step(0, 8'd0, 9'h0A3);
        chk("e_idle_after_rst", core_rst, 1);

        step(0, 8'd0, 9'h0A3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
